// File: rtl/sched_tick_gen.sv
// Multi-channel programmable tick scheduler: per-channel offset/period down-counters under a run-length FSM.
// Optional one-shot channel mode is built when SCHED_TICK_ONESHOT_EN is defined.
module sched_tick_gen #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [CNT_W-1:0] limit,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   phase,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] offset_q   [NCH];
  logic [CNT_W-1:0] period_q   [NCH];
  logic [CNT_W-1:0] cnt_q      [NCH];
  logic [CNT_W-1:0] cnt_d      [NCH];
  logic [CNT_W-1:0] eff_offset [NCH];
  logic [CNT_W-1:0] eff_period [NCH];
  logic [NCH-1:0]   wr_sel;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   tick_d, phase_d;
  logic [CNT_W-1:0] cyc_d, cyc_inc;

`ifdef SCHED_TICK_ONESHOT_EN
  logic [NCH-1:0] oneshot_q, spent_q, spent_d, eff_oneshot;
`else
  logic unused_oneshot;
  assign unused_oneshot = cfg_oneshot;
`endif

  // Next-state and datapath; a config write in the same cycle is forwarded so start sees it.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_cnt;
    cyc_inc = cyc_cnt + CNT_W'(1);
    tick_d  = '0;
    phase_d = phase;
    cnt_d   = cnt_q;
    wr_sel  = '0;
    en      = '0;
`ifdef SCHED_TICK_ONESHOT_EN
    spent_d     = spent_q;
    eff_oneshot = oneshot_q;
`endif
    for (int i = 0; i < int'(NCH); i++) begin
      wr_sel[i]     = cfg_we && (32'(cfg_ch) == 32'(i));
      eff_offset[i] = wr_sel[i] ? cfg_offset : offset_q[i];
      eff_period[i] = wr_sel[i] ? cfg_period : period_q[i];
`ifdef SCHED_TICK_ONESHOT_EN
      if (wr_sel[i]) eff_oneshot[i] = cfg_oneshot;
      en[i] = (eff_period[i] != '0) && !spent_q[i];
`else
      en[i] = (eff_period[i] != '0);
`endif
    end

    if (start) begin
      state_d = RUN;
      cyc_d   = '0;
      phase_d = '0;
      for (int i = 0; i < int'(NCH); i++) cnt_d[i] = eff_offset[i];
`ifdef SCHED_TICK_ONESHOT_EN
      spent_d = '0;
`endif
    end else if (state_q == RUN) begin
      cyc_d = cyc_inc;
      if ((limit != '0) && (cyc_inc == limit)) state_d = DONE;
      for (int i = 0; i < int'(NCH); i++) begin
        if (en[i]) begin
          if (cnt_q[i] == '0) begin
            tick_d[i]  = 1'b1;
            phase_d[i] = ~phase[i];
            cnt_d[i]   = eff_period[i] - CNT_W'(1);
`ifdef SCHED_TICK_ONESHOT_EN
            spent_d[i] = eff_oneshot[i];
`endif
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // State, outputs and config storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      cyc_cnt <= '0;
      tick    <= '0;
      phase   <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        offset_q[i] <= '0;
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
`ifdef SCHED_TICK_ONESHOT_EN
      oneshot_q <= '0;
      spent_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
      cyc_cnt <= cyc_d;
      tick    <= tick_d;
      phase   <= phase_d;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i]    <= cnt_d[i];
        offset_q[i] <= eff_offset[i];
        period_q[i] <= eff_period[i];
      end
`ifdef SCHED_TICK_ONESHOT_EN
      oneshot_q <= eff_oneshot;
      spent_q   <= spent_d;
`endif
    end
  end

endmodule

// File: tb/tb_sched_tick_gen.sv
// Directed bench for sched_tick_gen: one NCH=4/CNT_W=16 instance and one NCH=3/CNT_W=4 instance.
module tb_sched_tick_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cfg_we, cfg_oneshot;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_offset, cfg_period, limit;
  logic [3:0]  tick, phase;
  logic        running, done;
  logic [15:0] cyc_cnt;

  logic        b_start, b_cfg_we;
  logic [1:0]  b_cfg_ch;
  logic [3:0]  b_cfg_offset, b_cfg_period, b_limit;
  logic [2:0]  b_tick, b_phase;
  logic        b_running, b_done;
  logic [3:0]  b_cyc_cnt;

  int checks = 0;
  int failures = 0;

  sched_tick_gen #(.NCH(4), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_offset(cfg_offset), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .limit(limit), .tick(tick), .phase(phase), .running(running), .done(done),
    .cyc_cnt(cyc_cnt)
  );

  sched_tick_gen #(.NCH(3), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
    .cfg_offset(b_cfg_offset), .cfg_period(b_cfg_period), .cfg_oneshot(1'b0),
    .limit(b_limit), .tick(b_tick), .phase(b_phase), .running(b_running), .done(b_done),
    .cyc_cnt(b_cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] off, input logic [15:0] per,
                     input logic os);
    cfg_we = 1'b1; cfg_ch = ch; cfg_offset = off; cfg_period = per; cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [3:0] rs_tick  [6] = '{4'b0010, 4'b0110, 4'b0011, 4'b0110, 4'b0010, 4'b0110};
  logic [3:0] rs_phase [6] = '{4'b0010, 4'b0100, 4'b0111, 4'b0001, 4'b0011, 4'b0101};

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_offset = '0;
    cfg_period = '0; cfg_oneshot = 1'b0; limit = '0;
    b_start = 1'b0; b_cfg_we = 1'b0; b_cfg_ch = '0; b_cfg_offset = '0;
    b_cfg_period = '0; b_limit = '0;
    repeat (2) step();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cyc", 32'(cyc_cnt), 0);
    rst_n = 1'b1;
    step();

    // Run 1: ch0 offset 4 period 10, ch1 offset 0 period 1, ch2 disabled, limit 21
    cfg(2'd0, 16'd4, 16'd10, 1'b0);
    cfg(2'd1, 16'd0, 16'd1, 1'b0);
    cfg(2'd2, 16'd3, 16'd0, 1'b0);
    limit = 16'd21;
    do_start();
    chk("s_running", 32'(running), 1);
    chk("s_cyc", 32'(cyc_cnt), 0);
    chk("s_tick", 32'(tick), 0);
    for (int k = 1; k <= 24; k++) begin
      logic [3:0] et, ep;
      et = {2'b00, 1'(k <= 21), 1'(k == 5 || k == 15)};
      ep = {2'b00, (k <= 21) ? 1'(k % 2) : 1'b1, 1'(k >= 5 && k < 15)};
      step();
      chk($sformatf("r1_tick_%0d", k), 32'(tick), 32'(et));
      chk($sformatf("r1_phase_%0d", k), 32'(phase), 32'(ep));
      chk($sformatf("r1_cyc_%0d", k), 32'(cyc_cnt), (k <= 21) ? k : 21);
      chk($sformatf("r1_done_%0d", k), 32'(done), 32'(k >= 21));
      chk($sformatf("r1_run_%0d", k), 32'(running), 32'(k < 21));
    end

    // Run 2: ch0 offset 2 period 5, free-run, restart at cycle 8 with a same-edge ch2 write
    cfg(2'd0, 16'd2, 16'd5, 1'b0);
    chk("done_hold", 32'(done), 1);
    chk("cyc_hold", 32'(cyc_cnt), 21);
    limit = 16'd0;
    do_start();
    chk("r2_done_clr", 32'(done), 0);
    chk("r2_cyc0", 32'(cyc_cnt), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("r2_tick0_%0d", k), 32'(tick[0]), 32'(k == 3 || k == 8));
    end
    chk("r2_phase0_c8", 32'(phase[0]), 0);
    chk("r2_cyc8", 32'(cyc_cnt), 8);
    start = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_offset = 16'd1; cfg_period = 16'd2;
    step();
    start = 1'b0; cfg_we = 1'b0;
    chk("rs_cyc", 32'(cyc_cnt), 0);
    chk("rs_phase", 32'(phase), 0);
    chk("rs_tick", 32'(tick), 0);
    chk("rs_running", 32'(running), 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rs_tick_%0d", k), 32'(tick), 32'(rs_tick[k-1]));
      chk($sformatf("rs_phase_%0d", k), 32'(phase), 32'(rs_phase[k-1]));
    end

    // Asynchronous reset mid-run clears config too
    rst_n = 1'b0;
    #2;
    chk("ar_tick", 32'(tick), 0);
    chk("ar_phase", 32'(phase), 0);
    chk("ar_running", 32'(running), 0);
    chk("ar_cyc", 32'(cyc_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    do_start();
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("pr_tick_%0d", k), 32'(tick), 0);
      chk($sformatf("pr_cyc_%0d", k), 32'(cyc_cnt), k);
    end
    chk("pr_running", 32'(running), 1);

    // Narrow instance: out-of-range channel write and free-run wrap
    b_cfg_we = 1'b1; b_cfg_ch = 2'd0; b_cfg_offset = 4'd1; b_cfg_period = 4'd4;
    step();
    b_cfg_ch = 2'd3; b_cfg_offset = 4'd0; b_cfg_period = 4'd1;
    step();
    b_cfg_we = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      step();
      chk($sformatf("w_tick_%0d", k), 32'(b_tick), (k >= 2 && (k - 2) % 4 == 0) ? 1 : 0);
      chk($sformatf("w_cyc_%0d", k), 32'(b_cyc_cnt), k % 16);
      chk($sformatf("w_done_%0d", k), 32'(b_done), 0);
    end
    chk("w_running", 32'(b_running), 1);

`ifdef SCHED_TICK_ONESHOT_EN
    cfg(2'd3, 16'd6, 16'd3, 1'b1);
    do_start();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("os_tick_%0d", k), 32'(tick), (k == 7) ? 32'h8 : 0);
      chk($sformatf("os_phase_%0d", k), 32'(phase), (k >= 7) ? 32'h8 : 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
